// File: rtl/rv32i_pkg.sv
// Shared RV32I encoder definitions: request op codes, base opcodes and the
// encoder FSM state type.
package rv32i_pkg;

    typedef enum logic [3:0] {
        OP_LUI    = 4'd0,
        OP_AUIPC  = 4'd1,
        OP_JAL    = 4'd2,
        OP_JALR   = 4'd3,
        OP_BRANCH = 4'd4,
        OP_LOAD   = 4'd5,
        OP_STORE  = 4'd6,
        OP_OPIMM  = 4'd7,
        OP_OP     = 4'd8
    } req_op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FULL  = 2'd2
    } enc_state_e;

endpackage

// File: rtl/rv32i_field_pack.sv
// Combinational packer: turns decoded instruction fields into an RV32I word
// and flags field combinations the decoder would reject.
module rv32i_field_pack
    import rv32i_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic [6:0] funct7;
    logic       shift_imm;

    always_comb begin
        word      = '0;
        illegal   = 1'b0;
        funct7    = {1'b0, alt, 5'b00000};
        shift_imm = (funct3 == 3'd1) || (funct3 == 3'd5);

        case (op)
            OP_LUI: begin
                word = {imm[31:12], rd, OPC_LUI};
            end
            OP_AUIPC: begin
                word = {imm[31:12], rd, OPC_AUIPC};
            end
            OP_JAL: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                illegal = imm[0];
            end
            OP_JALR: begin
                word    = {imm[11:0], rs1, funct3, rd, OPC_JALR};
                illegal = (funct3 != 3'd0);
            end
            OP_BRANCH: begin
                word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
                illegal = (funct3 == 3'd2) || (funct3 == 3'd3) || imm[0];
            end
            OP_LOAD: begin
                word    = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
                illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OP_STORE: begin
                word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
                illegal = (funct3 > 3'd2);
            end
            OP_OPIMM: begin
                // Shift-immediates carry the SRAI selector in the upper immediate bits
                if (shift_imm) begin
                    word = {funct7, imm[4:0], rs1, funct3, rd, OPC_OPIMM};
                end else begin
                    word = {imm[11:0], rs1, funct3, rd, OPC_OPIMM};
                end
                illegal = alt && (funct3 != 3'd5);
            end
            OP_OP: begin
                word    = {funct7, rs2, rs1, funct3, rd, OPC_OP};
                illegal = alt && !((funct3 == 3'd0) || (funct3 == 3'd5));
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv32i_inst_encoder.sv
// RV32I instruction encoder: accepts decoded fields, packs them and streams the
// legal words into instruction memory, one word per accepted request.
module rv32i_inst_encoder
    import rv32i_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [2:0]        req_funct3,
    input  logic              req_alt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              err_illegal,
    output logic [ADDR_W:0]   words_written,
    output logic              full
);

    localparam logic [ADDR_W-1:0] BASE_C     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_OFS_C = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W + 1)'(DEPTH);

    enc_state_e        state_q, state_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;

    logic [31:0]       packed_word;
    logic              pack_illegal;
    logic              accept;
    logic [ADDR_W:0]   count_inc;

    rv32i_field_pack u_pack (
        .op      (req_op),
        .funct3  (req_funct3),
        .alt     (req_alt),
        .rd      (req_rd),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .imm     (req_imm),
        .word    (packed_word),
        .illegal (pack_illegal)
    );

    assign accept = req_valid && ready_q;

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = 1'b0;
        count_d   = count_q;
        full_d    = full_q;
        count_inc = count_q + (ADDR_W + 1)'(1);

        if (clear) begin
            // Restart wins over any pending write, even one completing this cycle
            state_d = ST_IDLE;
            ready_d = 1'b1;
            we_d    = 1'b0;
            addr_d  = BASE_C;
            count_d = '0;
            full_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (pack_illegal) begin
                            err_d = 1'b1;
                        end else begin
                            wdata_d = packed_word;
                            we_d    = 1'b1;
                            ready_d = 1'b0;
                            state_d = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (imem_ready) begin
                        we_d    = 1'b0;
                        count_d = count_inc;
                        // Wrap within the DEPTH-word window that starts at BASE_ADDR
                        addr_d  = ((addr_q - BASE_C) == LAST_OFS_C) ? BASE_C
                                                                     : addr_q + ADDR_W'(1);
                        if (count_inc == DEPTH_C) begin
                            state_d = ST_FULL;
                            full_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            ready_d = 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    state_d = ST_FULL;
                end
                default: begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    we_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= BASE_C;
            wdata_q <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    assign req_ready     = ready_q;
    assign imem_we       = we_q;
    assign imem_addr     = addr_q;
    assign imem_wdata    = wdata_q;
    assign err_illegal   = err_q;
    assign words_written = count_q;
    assign full          = full_q;

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Self-checking bench for rv32i_inst_encoder: directed cases plus randomized
// requests checked against a behavioural encoding and write-count model.
module tb_rv32i_inst_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int BASE   = 0;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              clear      = 1'b0;
    logic              req_valid  = 1'b0;
    logic [3:0]        req_op     = '0;
    logic [2:0]        req_funct3 = '0;
    logic              req_alt    = 1'b0;
    logic [4:0]        req_rd     = '0;
    logic [4:0]        req_rs1    = '0;
    logic [4:0]        req_rs2    = '0;
    logic [31:0]       req_imm    = '0;
    logic              imem_ready = 1'b0;
    logic              req_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              err_illegal;
    logic [ADDR_W:0]   words_written;
    logic              full;

    int checks    = 0;
    int errors    = 0;
    int exp_count = 0;
    int exp_addr  = BASE;

    always #5 clk = ~clk;

    rv32i_inst_encoder #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_funct3    (req_funct3),
        .req_alt       (req_alt),
        .req_rd        (req_rd),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .req_imm       (req_imm),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .imem_ready    (imem_ready),
        .err_illegal   (err_illegal),
        .words_written (words_written),
        .full          (full)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Legality straight from the rule list
    function automatic bit ref_legal(input int op, input int f3, input int alt, input logic [31:0] imm);
        if (op >= 9) return 0;
        if (op == 3 && f3 != 0) return 0;
        if (op == 4 && (f3 == 2 || f3 == 3)) return 0;
        if (op == 5 && (f3 == 3 || f3 == 6 || f3 == 7)) return 0;
        if (op == 6 && f3 > 2) return 0;
        if ((op == 4 || op == 2) && (imm % 2 == 1)) return 0;
        if (op == 8 && alt == 1 && !(f3 == 0 || f3 == 5)) return 0;
        if (op == 7 && alt == 1 && f3 != 5) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] bits(input logic [31:0] v, input int lo, input int n);
        return (v >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    function automatic logic [31:0] ref_word(input int op, input int f3, input int alt, input int d,
                                             input int s1, input int s2, input logic [31:0] imm);
        logic [31:0] rdf, s1f, s2f, f3f, opc;
        rdf = 32'(d) << 7;
        s1f = 32'(s1) << 15;
        s2f = 32'(s2) << 20;
        f3f = 32'(f3) << 12;
        case (op)
            0: opc = 32'h37;  1: opc = 32'h17;  2: opc = 32'h6F;
            3: opc = 32'h67;  4: opc = 32'h63;  5: opc = 32'h03;
            6: opc = 32'h23;  7: opc = 32'h13;  default: opc = 32'h33;
        endcase
        case (op)
            0, 1: return (imm & 32'hFFFF_F000) | rdf | opc;
            2: return (bits(imm, 20, 1) << 31) | (bits(imm, 1, 10) << 21) | (bits(imm, 11, 1) << 20)
                      | (bits(imm, 12, 8) << 12) | rdf | opc;
            3, 5: return (bits(imm, 0, 12) << 20) | s1f | f3f | rdf | opc;
            4: return (bits(imm, 12, 1) << 31) | (bits(imm, 5, 6) << 25) | s2f | s1f | f3f
                      | (bits(imm, 1, 4) << 8) | (bits(imm, 11, 1) << 7) | opc;
            6: return (bits(imm, 5, 7) << 25) | s2f | s1f | f3f | (bits(imm, 0, 5) << 7) | opc;
            7: begin
                if (f3 == 1 || f3 == 5)
                    return (32'(alt) << 30) | (bits(imm, 0, 5) << 20) | s1f | f3f | rdf | opc;
                return (bits(imm, 0, 12) << 20) | s1f | f3f | rdf | opc;
            end
            8: return (32'(alt) << 30) | s2f | s1f | f3f | rdf | opc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_status(input string tag);
        check({tag, ".we"}, imem_we, 0);
        check({tag, ".count"}, words_written, exp_count);
        check({tag, ".addr"}, imem_addr, exp_addr);
        check({tag, ".full"}, full, exp_count == DEPTH);
        check({tag, ".ready"}, req_ready, exp_count != DEPTH);
    endtask

    // Called and returns just after a falling edge; caller guarantees not full
    task automatic send(input string tag, input int op, input int f3, input int alt, input int d,
                        input int s1, input int s2, input logic [31:0] imm, input int stall,
                        input bit clr_end, input logic [31:0] lit);
        logic [31:0] w;
        bit ok;
        ok = ref_legal(op, f3, alt, imm);
        w  = ref_word(op, f3, alt, d, s1, s2, imm);
        req_op = 4'(op); req_funct3 = 3'(f3); req_alt = 1'(alt);
        req_rd = 5'(d); req_rs1 = 5'(s1); req_rs2 = 5'(s2); req_imm = imm;
        req_valid  = 1'b1;
        imem_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        if (!ok) begin
            check({tag, ".err"}, err_illegal, 1);
            check_status({tag, ".ill"});
            @(negedge clk);
            check({tag, ".err_pulse"}, err_illegal, 0);
            check({tag, ".we_ill"}, imem_we, 0);
            return;
        end
        check({tag, ".we"}, imem_we, 1);
        check({tag, ".wdata"}, imem_wdata, w);
        if (lit != 32'h0) check({tag, ".lit"}, imem_wdata, lit);
        check({tag, ".addr"}, imem_addr, exp_addr);
        check({tag, ".ready_busy"}, req_ready, 0);
        check({tag, ".err0"}, err_illegal, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, ".hold_we"}, imem_we, 1);
            check({tag, ".hold_wdata"}, imem_wdata, w);
            check({tag, ".hold_addr"}, imem_addr, exp_addr);
            check({tag, ".hold_ready"}, req_ready, 0);
            check({tag, ".hold_count"}, words_written, exp_count);
        end
        imem_ready = 1'b1;
        clear      = clr_end;
        @(negedge clk);
        imem_ready = 1'b0;
        clear      = 1'b0;
        if (clr_end) begin
            exp_count = 0;
            exp_addr  = BASE;
        end else begin
            exp_count++;
            exp_addr = (exp_addr - BASE + 1) % DEPTH + BASE;
        end
        check_status({tag, ".done"});
    endtask

    task automatic do_clear(input string tag);
        clear = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        exp_count = 0;
        exp_addr  = BASE;
        check_status(tag);
        check({tag, ".err"}, err_illegal, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int op, f3, alt, stall;
        logic [31:0] imm;
        bit clr_end;

        repeat (2) @(negedge clk);
        check("rst.we", imem_we, 0);
        check("rst.err", err_illegal, 0);
        check("rst.addr", imem_addr, BASE);
        check("rst.count", words_written, 0);
        check("rst.full", full, 0);
        check("rst.wdata", imem_wdata, 0);
        check("rst.ready", req_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        send("addi", 7, 0, 0, 1, 0, 0, 32'd5, 0, 0, 32'h0050_0093);
        send("sub",  8, 0, 1, 3, 1, 2, 32'd0, 0, 0, 32'h4020_81B3);
        send("beq",  4, 0, 0, 0, 1, 2, 32'd8, 0, 0, 32'h0020_8463);
        send("sw",   6, 2, 0, 0, 1, 2, 32'd4, 5, 0, 32'h0020_A223);

        // Full: further requests must be ignored
        req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_status("full_hold");
            check("full_hold.err", err_illegal, 0);
        end
        req_valid = 1'b0;
        do_clear("clr1");

        send("lui", 0, 0, 0, 5, 0, 0, 32'h1234_5000, 1, 0, 32'h1234_52B7);
        send("jal", 2, 0, 0, 1, 0, 0, 32'd2048, 0, 0, 32'h0010_00EF);

        send("ill_load", 5, 3, 0, 1, 2, 3, 32'd0, 0, 0, 32'h0);
        send("ill_bimm", 4, 0, 0, 0, 1, 2, 32'd3, 0, 0, 32'h0);
        send("ill_op12", 12, 0, 0, 1, 2, 3, 32'd0, 0, 0, 32'h0);

        send("srai", 7, 5, 1, 4, 6, 0, 32'd7, 0, 0, 32'h4073_5213);
        send("sb_full", 6, 0, 0, 0, 3, 4, 32'hFFFF_FFFF, 2, 0, 32'hFE41_8FA3);
        do_clear("clr2");
        send("clr_on_ready", 8, 0, 0, 1, 2, 3, 32'd0, 2, 1, 32'h0031_00B3);

        // Asynchronous reset while a write is pending
        req_op = 4'd7; req_funct3 = 3'd0; req_alt = 1'b0; req_imm = 32'd1;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("arst.pre_we", imem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst.we", imem_we, 0);
        check("arst.count", words_written, 0);
        check("arst.ready", req_ready, 1);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_count = 0;
        exp_addr  = BASE;
        @(negedge clk);
        check_status("arst.after");

        for (int n = 0; n < 80; n++) begin
            if (exp_count == DEPTH || $urandom_range(0, 15) == 0) do_clear("rnd_clr");
            op    = $urandom_range(0, 10);
            f3    = $urandom_range(0, 7);
            alt   = ($urandom_range(0, 3) == 0) ? 1 : 0;
            imm   = $urandom;
            if ($urandom_range(0, 3) != 0) imm = imm & 32'hFFFF_FFFE;
            stall   = $urandom_range(0, 3);
            clr_end = ($urandom_range(0, 9) == 0);
            send("rnd", op, f3, alt, $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), imm, stall, clr_end, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
